// File: rtl/zbt_pkg.sv
// Shared widths, default geometry and grant encoding for the ZBT frame arbiter.
package zbt_pkg;

  localparam int ZBT_DATA_W      = 36;
  localparam int ADDR_W_DEF      = 19;
  localparam int FRAME_WORDS_DEF = 76800;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_RD   = 2'd1,
    GRANT_WR   = 2'd2
  } grant_t;

endpackage

// File: rtl/zbt_write_fifo.sv
// Small synchronous write-word FIFO; flush empties it and a same-cycle push lands after the flush.
module zbt_write_fifo
  import zbt_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [ZBT_DATA_W-1:0] din,
  output logic [ZBT_DATA_W-1:0] dout,
  output logic                  empty,
  output logic                  full
);

  localparam int PW = $clog2(DEPTH);

  logic [ZBT_DATA_W-1:0] mem [DEPTH];
  logic [PW:0]           wr_ptr;
  logic [PW:0]           rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  // A pop frees the slot the push reuses, so full+pop still accepts the push.
  assign do_push = push && (flush || !full || pop);
  assign do_pop  = pop && !empty && !flush;
  assign dout    = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (flush)       rd_ptr <= wr_ptr;
      else if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= din;
  end

endmodule

// File: rtl/zbt_frame_arbiter.sv
// Single-port ZBT sharing: display reads win, queued frame writes drain into sequential addresses.
module zbt_frame_arbiter
  import zbt_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int FRAME_WORDS = FRAME_WORDS_DEF,
  parameter int FIFO_DEPTH  = 4,
  parameter int ZBT_LAT     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_valid,
  input  logic [ZBT_DATA_W-1:0] wr_data,
  input  logic                  frame_start,
  input  logic                  rd_req,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic                  rd_valid,
  output logic [ZBT_DATA_W-1:0] rd_data,
  output logic                  wr_overflow,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [ZBT_DATA_W-1:0] mem_write_data,
  input  logic [ZBT_DATA_W-1:0] mem_read_data
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

  grant_t                grant;
  logic                  pop;
  logic [ZBT_DATA_W-1:0] fifo_dout;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [ADDR_W-1:0]     wr_addr;
  logic [ZBT_DATA_W-1:0] wd_pipe [ZBT_LAT];
  logic [ZBT_LAT-1:0]    wv_pipe;
  logic [ZBT_LAT:0]      rd_tag;

  always_comb begin
    grant = GRANT_NONE;
    if (rd_req)           grant = GRANT_RD;
    else if (!fifo_empty) grant = GRANT_WR;
  end

  assign pop = (grant == GRANT_WR);

  zbt_write_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_valid),
    .pop   (pop),
    .flush (frame_start),
    .din   (wr_data),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      wr_addr        <= '0;
      wv_pipe        <= '0;
      rd_tag         <= '0;
      rd_valid       <= 1'b0;
      rd_data        <= '0;
      wr_overflow    <= 1'b0;
      for (int i = 0; i < ZBT_LAT; i++) wd_pipe[i] <= '0;
    end else begin
      mem_we <= pop;
      if (grant == GRANT_RD)      mem_addr <= rd_addr;
      else if (grant == GRANT_WR) mem_addr <= wr_addr;

      // A write popped alongside frame_start has already taken the old address.
      if (frame_start) wr_addr <= '0;
      else if (pop)    wr_addr <= (wr_addr == LAST_ADDR) ? '0 : wr_addr + ADDR_W'(1);

      wv_pipe[0] <= pop;
      if (pop) wd_pipe[0] <= fifo_dout;
      for (int i = 1; i < ZBT_LAT; i++) begin
        wv_pipe[i] <= wv_pipe[i-1];
        wd_pipe[i] <= wd_pipe[i-1];
      end
      if (wv_pipe[ZBT_LAT-1]) mem_write_data <= wd_pipe[ZBT_LAT-1];

      rd_tag   <= {rd_tag[ZBT_LAT-1:0], grant == GRANT_RD};
      rd_valid <= rd_tag[ZBT_LAT];
      if (rd_tag[ZBT_LAT]) rd_data <= mem_read_data;

      if (wr_valid && fifo_full && !pop && !frame_start) wr_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_zbt_frame_arbiter.sv
// Randomized bench for zbt_frame_arbiter against a cycle-scheduled queue model of the arbitration rules.
module tb_zbt_frame_arbiter;
  import zbt_pkg::*;

  localparam int AW    = 19;
  localparam int FW    = 8;
  localparam int DEPTH = 4;
  localparam int LAT   = 2;
  localparam int R     = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_valid = 1'b0;
  logic [35:0]   wr_data = '0;
  logic          frame_start = 1'b0;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_valid;
  logic [35:0]   rd_data;
  logic          wr_overflow;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [35:0]   mem_write_data;
  logic [35:0]   mem_read_data = '0;

  zbt_frame_arbiter #(
    .ADDR_W(AW), .FRAME_WORDS(FW), .FIFO_DEPTH(DEPTH), .ZBT_LAT(LAT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .wr_valid       (wr_valid),
    .wr_data        (wr_data),
    .frame_start    (frame_start),
    .rd_req         (rd_req),
    .rd_addr        (rd_addr),
    .rd_valid       (rd_valid),
    .rd_data        (rd_data),
    .wr_overflow    (wr_overflow),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: FIFO contents as a queue, outputs scheduled onto future cycles.
  logic [35:0]   q[$];
  int unsigned   m_waddr;
  bit            m_ovf;
  bit            m_we;
  logic [AW-1:0] m_addr;
  logic [35:0]   m_wd;
  bit            wd_set [R];
  logic [35:0]   wd_val [R];
  bit            rv_set [R];
  logic [35:0]   mrd    [R];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_waddr = 0;
    m_ovf   = 0;
    m_we    = 0;
    m_addr  = '0;
    m_wd    = '0;
    for (int i = 0; i < R; i++) begin
      wd_set[i] = 0;
      wd_val[i] = '0;
      rv_set[i] = 0;
      mrd[i]    = '0;
    end
  endtask

  task automatic check_cycle();
    int k;
    k = cyc % R;
    if (wd_set[k]) m_wd = wd_val[k];
    wd_set[k] = 0;
    check_eq("mem_we", mem_we, m_we);
    check_eq("mem_addr", mem_addr, m_addr);
    check_eq("mem_write_data", mem_write_data, m_wd);
    check_eq("rd_valid", rd_valid, rv_set[k]);
    if (rv_set[k]) check_eq("rd_data", rd_data, mrd[(cyc + R - 1) % R]);
    rv_set[k] = 0;
    check_eq("wr_overflow", wr_overflow, m_ovf);
  endtask

  task automatic model_step();
    logic [35:0] w;
    if (rd_req) begin
      m_we   = 0;
      m_addr = rd_addr;
      rv_set[(cyc + LAT + 2) % R] = 1;
    end else if (q.size() > 0) begin
      w      = q.pop_front();
      m_we   = 1;
      m_addr = AW'(m_waddr);
      wd_set[(cyc + 1 + LAT) % R] = 1;
      wd_val[(cyc + 1 + LAT) % R] = w;
      m_waddr = (m_waddr + 1) % FW;
    end else begin
      m_we = 0;
    end
    if (frame_start) begin
      m_waddr = 0;
      q.delete();
    end
    if (wr_valid) begin
      if (frame_start || q.size() < DEPTH) q.push_back(wr_data);
      else m_ovf = 1;
    end
  endtask

  task automatic drive_rdata();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    mem_read_data = r[35:0];
    mrd[cyc % R] = mem_read_data;
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    model_step();
    @(posedge clk);
    cyc++;
    #1;
    drive_rdata();
  endtask

  task automatic idle_inputs();
    wr_valid = 0; frame_start = 0; rd_req = 0;
  endtask

  task automatic idle(input int n);
    idle_inputs();
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1;
    idle_inputs();
    #1;
    check_eq("rst_mem_we", mem_we, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_mem_write_data", mem_write_data, 0);
    check_eq("rst_rd_valid", rd_valid, 0);
    check_eq("rst_rd_data", rd_data, 0);
    check_eq("rst_wr_overflow", wr_overflow, 0);
    model_clear();
    @(posedge clk);
    cyc++;
    #1;
    reset = 0;
    drive_rdata();
  endtask

  initial begin
    logic [63:0] r;
    model_clear();
    #1;
    do_reset();

    // Single write
    wr_valid = 1; wr_data = 36'h0AABBCCDD;
    tick();
    idle_inputs();
    tick();
    check_eq("sw_we", mem_we, 1);
    check_eq("sw_addr", mem_addr, 0);
    tick();
    tick();
    check_eq("sw_data", mem_write_data, 36'h0AABBCCDD);
    idle(3);

    // Single read
    rd_req = 1; rd_addr = 19'h00010;
    tick();
    rd_req = 0;
    check_eq("sr_addr", mem_addr, 19'h00010);
    tick();
    tick();
    mem_read_data = 36'h123456789;
    mrd[cyc % R] = mem_read_data;
    tick();
    check_eq("sr_valid", rd_valid, 1);
    check_eq("sr_data", rd_data, 36'h123456789);
    tick();
    check_eq("sr_valid_end", rd_valid, 0);
    idle(3);

    // Collision: reads for 3 cycles while two writes queue
    for (int i = 0; i < 3; i++) begin
      rd_req = 1; rd_addr = AW'(19'h100 + i);
      wr_valid = (i < 2); wr_data = 36'h0C0DE0000 + 36'(i);
      tick();
    end
    idle(8);

    // Overflow: 8 reads, 5 writes, word 5 dropped
    frame_start = 1;
    tick();
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      rd_req = 1; rd_addr = AW'(i);
      wr_valid = (i < 5); wr_data = 36'(i + 1);
      tick();
    end
    idle(10);
    check_eq("ovf_sticky", wr_overflow, 1);

    // Mid-stream reset with two words queued
    rd_req = 1; wr_valid = 1; wr_data = 36'h111;
    tick();
    wr_data = 36'h222;
    tick();
    do_reset();
    idle(8);

    // Wrap: nine writes into an 8-word frame
    for (int i = 0; i < 9; i++) begin
      wr_valid = 1; wr_data = 36'h900 + 36'(i);
      tick();
      idle_inputs();
      tick();
    end
    idle(6);

    // frame_start flushes queued words; concurrent write becomes word 0
    rd_req = 1; wr_valid = 1; wr_data = 36'hA1;
    tick();
    wr_data = 36'hA2;
    tick();
    frame_start = 1; wr_data = 36'hF;
    tick();
    idle_inputs();
    tick();
    check_eq("fs_we", mem_we, 1);
    check_eq("fs_addr", mem_addr, 0);
    idle(6);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        rd_req      = ($urandom_range(0, 99) < 35);
        rd_addr     = AW'($urandom());
        wr_valid    = ($urandom_range(0, 99) < 45);
        r           = {$urandom(), $urandom()};
        wr_data     = r[35:0];
        frame_start = ($urandom_range(0, 99) < 2);
        tick();
      end
    end
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
